// File: rtl/div_unit_if.sv
// Execute-stage divider bus: issue controls and operands from the pipeline,
// registered {HI, LO} result and the ready/stall handshake back to it.
interface div_unit_if;
  logic        start;
  logic        signeddiv;
  logic        annul;
  logic [31:0] a;
  logic [31:0] b;
  logic [63:0] result;
  logic        ready;
  logic        stall;

  // Pipeline side: issues divisions, consumes result and stall.
  modport master (
    output start, signeddiv, annul, a, b,
    input  result, ready, stall
  );

  // Divider side.
  modport slave (
    input  start, signeddiv, annul, a, b,
    output result, ready, stall
  );
endinterface

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for MIPS DIV/DIVU.
// Divides magnitudes over 32 iterations, then fixes up signs when
// loading the {remainder, quotient} result register.
module div_unit (
  input  logic       clk,
  input  logic       rst,
  div_unit_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DIVZERO = 2'd1,
    ST_ON      = 2'd2,
    ST_END     = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [32:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] dvsr_q, dvsr_d;
  logic        qneg_q, qneg_d;
  logic        rneg_q, rneg_d;
  logic [63:0] result_q, result_d;

  logic        start_ok;
  logic        b_zero;
  logic        last_iter;
  logic [32:0] shift_rem;
  logic [31:0] shift_quo;
  logic [33:0] trial;
  logic [32:0] iter_rem;
  logic [31:0] iter_quo;
  logic [31:0] fix_quo;
  logic [31:0] fix_rem;

  assign start_ok  = bus.start & ~bus.annul;
  assign b_zero    = (bus.b == 32'd0);
  assign last_iter = (cnt_q == 5'd31);

  // One restoring-division step on {rem, quo}, plus the sign fix-up of its outcome.
  always_comb begin
    // NOTE: combinational logic uses blocking '=' so later statements see the updated value.
    shift_rem = {rem_q[31:0], quo_q[31]};
    shift_quo = {quo_q[30:0], 1'b0};
    trial     = {1'b0, shift_rem} - {2'b00, dvsr_q};
    if (trial[33]) begin
      iter_rem = shift_rem;
      iter_quo = shift_quo;
    end else begin
      iter_rem = trial[32:0];
      iter_quo = {shift_quo[31:1], 1'b1};
    end
    fix_quo = qneg_q ? (32'd0 - iter_quo) : iter_quo;
    fix_rem = rneg_q ? (32'd0 - iter_rem[31:0]) : iter_rem[31:0];
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking '<=' so all registers update together.
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; annul aborts any division in flight.
  always_comb begin
    // NOTE: default first so no path leaves state_d unassigned and no latch is inferred.
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_ok) state_d = b_zero ? ST_DIVZERO : ST_ON;
      end
      ST_ON: begin
        if (bus.annul)     state_d = ST_IDLE;
        else if (last_iter) state_d = ST_END;
      end
      ST_DIVZERO: begin
        state_d = bus.annul ? ST_IDLE : ST_END;
      end
      ST_END: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs: stall holds F/D/E until the END cycle; ready pulses in END unless annulled.
  always_comb begin
    bus.stall  = 1'b0;
    bus.ready  = 1'b0;
    bus.result = result_q;
    unique case (state_q)
      ST_IDLE:    bus.stall = ~bus.annul & bus.start;
      ST_ON:      bus.stall = ~bus.annul;
      ST_DIVZERO: bus.stall = ~bus.annul;
      ST_END:     bus.ready = ~bus.annul;
      default:    bus.stall = 1'b0;
    endcase
  end

  // Datapath next values: operand capture, iteration, result load.
  always_comb begin
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvsr_d   = dvsr_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    result_d = result_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          cnt_d = 5'd0;
          rem_d = 33'd0;
          if (b_zero) begin
            // Raw dividend is kept so it can be returned as the remainder.
            quo_d  = bus.a;
            dvsr_d = 32'd0;
            qneg_d = 1'b0;
            rneg_d = 1'b0;
          end else if (bus.signeddiv) begin
            quo_d  = bus.a[31] ? (32'd0 - bus.a) : bus.a;
            dvsr_d = bus.b[31] ? (32'd0 - bus.b) : bus.b;
            rneg_d = bus.a[31];
            qneg_d = bus.a[31] ^ bus.b[31];
          end else begin
            quo_d  = bus.a;
            dvsr_d = bus.b;
            qneg_d = 1'b0;
            rneg_d = 1'b0;
          end
        end
      end
      ST_ON: begin
        if (!bus.annul) begin
          rem_d = iter_rem;
          quo_d = iter_quo;
          cnt_d = cnt_q + 5'd1;
          if (last_iter) result_d = {fix_rem, fix_quo};
        end
      end
      ST_DIVZERO: begin
        if (!bus.annul) result_d = {quo_q, 32'hFFFF_FFFF};
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= 5'd0;
      rem_q    <= 33'd0;
      quo_q    <= 32'd0;
      dvsr_q   <= 32'd0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      result_q <= 64'd0;
    end else begin
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvsr_q   <= dvsr_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      result_q <= result_d;
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed cases plus random divisions
// compared against an arithmetic reference model.
module tb_div_unit;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  div_unit_if bus ();

  div_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          errors = 0;
  int          checks = 0;
  int unsigned cyc    = 0;
  logic [63:0] last_result = 64'd0;
  int unsigned ready_cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference: MIPS DIV/DIVU semantics with the divide-by-zero convention.
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                          input logic sgn);
    int sa, sb, q, r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (!sgn) return {a % b, a / b};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
    sa = a;
    sb = b;
    q  = sa / sb;
    r  = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // Issue one division at the current cycle and follow it to END.
  // Entered and left just after a rising edge.
  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                         input bit ann_end);
    logic [63:0] exp;
    int lat;
    exp = ref_div(a, b, sgn);
    lat = (b == 32'd0) ? 2 : 33;
    bus.start     = 1'b1;
    bus.a         = a;
    bus.b         = b;
    bus.signeddiv = sgn;
    bus.annul     = 1'b0;
    for (int k = 0; k <= lat; k++) begin
      if (ann_end && k == lat) bus.annul = 1'b1;
      @(negedge clk);
      if (k == lat) begin
        if (ann_end) begin
          check("ready_annul_end", bus.ready, 1'b0);
        end else begin
          check("ready_end", bus.ready, 1'b1);
          check("result", bus.result, exp);
          ready_cyc = cyc;
        end
        check("stall_end", bus.stall, 1'b0);
      end else begin
        check("stall_busy", bus.stall, 1'b1);
        check("ready_busy", bus.ready, 1'b0);
      end
      @(posedge clk);
      #1;
      bus.start     = 1'b0;
      bus.annul     = 1'b0;
      // Operand changes after capture must not matter.
      bus.a         = $urandom;
      bus.b         = $urandom;
      bus.signeddiv = 1'($urandom_range(0, 1));
    end
    if (ann_end) check("result_after_annul_end", bus.result, exp);
    last_result = exp;
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic        rs;
    int unsigned first_ready;

    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.signeddiv = 1'b0;
    bus.annul     = 1'b0;
    bus.a         = 32'd0;
    bus.b         = 32'd0;
    #1;
    check("reset_result", bus.result, 64'd0);
    check("reset_ready", bus.ready, 1'b0);
    check("reset_stall", bus.stall, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Directed cases.
    run_div(32'd100, 32'd7, 1'b0, 1'b0);
    run_div(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0);
    run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
    run_div(32'd5, 32'd0, 1'b0, 1'b0);
    run_div(32'hFFFF_FFFB, 32'd0, 1'b1, 1'b0);

    // Annul at cycle 10 of ON: no ready, result kept, then a normal division.
    bus.start = 1'b1; bus.a = 32'd1000; bus.b = 32'd3; bus.signeddiv = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    bus.annul = 1'b1;
    @(negedge clk);
    check("stall_annul_on", bus.stall, 1'b0);
    check("ready_annul_on", bus.ready, 1'b0);
    @(posedge clk); #1;
    bus.annul = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      check("idle_after_annul_stall", bus.stall, 1'b0);
      check("idle_after_annul_ready", bus.ready, 1'b0);
    end
    check("result_kept_after_annul", bus.result, last_result);
    @(posedge clk); #1;
    run_div(32'd9, 32'd3, 1'b0, 1'b0);

    // Asynchronous reset during cycle 15 of a division.
    bus.start = 1'b1; bus.a = 32'd123456; bus.b = 32'd77; bus.signeddiv = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (14) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid_result", bus.result, 64'd0);
    check("rst_mid_ready", bus.ready, 1'b0);
    check("rst_mid_stall", bus.stall, 1'b0);
    bus.start = 1'b1;
    #1;
    check("rst_stall_follows_start", bus.stall, 1'b1);
    bus.start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    run_div(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);

    // Back-to-back: second ready 34 cycles after the first.
    run_div(32'd10, 32'd3, 1'b0, 1'b0);
    first_ready = ready_cyc;
    run_div(32'hFFFF_FFF6, 32'd3, 1'b1, 1'b0);
    check("b2b_ready_spacing", 64'(ready_cyc - first_ready), 64'd34);

    // Annul in END: ready suppressed, result still takes the new value.
    run_div(32'd77, 32'd5, 1'b0, 1'b1);

    // Random divisions with a bias toward edge operands.
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 5))
        0:       ra = 32'h8000_0000;
        1:       ra = 32'hFFFF_FFFF;
        2:       ra = 32'($urandom_range(0, 50));
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1:       rb = 32'd1;
        2:       rb = 32'hFFFF_FFFF;
        3:       rb = 32'($urandom_range(1, 20));
        4:       rb = 32'h8000_0000;
        default: rb = $urandom;
      endcase
      rs = 1'($urandom_range(0, 1));
      run_div(ra, rb, rs, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
